// File: rtl/stg_ma_pkg.sv
// ---------------------------------------------------------------------------
// stg_ma_pkg -- shared pipeline constants and helpers.
//
// Holds the opcode and size constants used by the memory-address stage
// (stg_ma) and the memory-operation stage (stg_mo), the NOP encoding used
// for bubbles, and is_mem_opc(), which both stages use to recognise the
// four memory opcodes.
// ---------------------------------------------------------------------------
package stg_ma_pkg;

    // Bus sizes
    localparam int SIZE_ADDR   = 16;
    localparam int HBIT_ADDR   = SIZE_ADDR - 1;
    localparam int SIZE_DATA   = 32;
    localparam int SIZE_OPC    = 6;
    localparam int SIZE_TGT_GP = 4;
    localparam int SIZE_TGT_SR = 2;

    // Opcodes
    localparam logic [SIZE_OPC-1:0] OPC_NOP     = 6'h00;
    localparam logic [SIZE_OPC-1:0] OPC_RU_ADD  = 6'h01;
    localparam logic [SIZE_OPC-1:0] OPC_RU_LDu  = 6'h10;
    localparam logic [SIZE_OPC-1:0] OPC_RU_STu  = 6'h11;
    localparam logic [SIZE_OPC-1:0] OPC_IU_STiu = 6'h21;
    localparam logic [SIZE_OPC-1:0] OPC_IS_STis = 6'h31;

    // Stage-4 control states
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } ma_state_e;

    // Latched pipeline bundle of the memory-address stage
    typedef struct packed {
        logic [SIZE_ADDR-1:0]   pc;
        logic [SIZE_DATA-1:0]   instr;
        logic [SIZE_OPC-1:0]    opc;
        logic [SIZE_TGT_GP-1:0] tgt_gp;
        logic                   tgt_gp_we;
        logic [SIZE_TGT_SR-1:0] tgt_sr;
        logic                   tgt_sr_we;
        logic [SIZE_DATA-1:0]   result;
        logic [SIZE_ADDR-1:0]   ea;
        logic                   mp;
    } ma_q_t;

    // True for every opcode that touches a memory bank
    function automatic logic is_mem_opc(input logic [SIZE_OPC-1:0] opc);
        return (opc == OPC_RU_LDu)  || (opc == OPC_RU_STu) ||
               (opc == OPC_IU_STiu) || (opc == OPC_IS_STis);
    endfunction

endpackage

// File: rtl/stg_ma_agu.sv
// ---------------------------------------------------------------------------
// stg_ma_agu -- address generation for the memory-address stage.
//
// Purely combinational: ea = base + offset (wraps, carry discarded) and the
// memory port select is the top address bit.
//
// Ports:
//   iw_base   in  SIZE_ADDR  address base operand
//   iw_offset in  SIZE_ADDR  address offset operand
//   ow_ea     out SIZE_ADDR  effective address
//   ow_mp     out 1          memory port (bank) select
// ---------------------------------------------------------------------------
module stg_ma_agu
    import stg_ma_pkg::*;
(
    input  logic [SIZE_ADDR-1:0] iw_base,
    input  logic [SIZE_ADDR-1:0] iw_offset,
    output logic [SIZE_ADDR-1:0] ow_ea,
    output logic                 ow_mp
);

    // Result is sized to SIZE_ADDR, so the carry out falls off naturally.
    assign ow_ea = iw_base + iw_offset;
    assign ow_mp = ow_ea[HBIT_ADDR];

endmodule

// File: rtl/stg_ma.sv
// ---------------------------------------------------------------------------
// stg_ma -- pipeline stage 4, memory address.
//
// Computes the effective address of memory ops, latches the pipeline bundle
// and presents it to stg_mo one cycle later. While the selected bank is busy
// the stage holds its op, stalls stages 1-3 and sends bubbles downstream so
// a store is never issued twice. After WAIT_MAX stalled cycles the op is
// dropped and ow_mem_fault pulses for one cycle.
//
// Parameters:
//   WAIT_MAX  maximum stalled cycles before drop, 1..(2^CNT_W)-1
//   CNT_W     wait-counter width
//
// Ports:
//   iw_clk, iw_rst             clock, asynchronous active-high reset
//   iw_flush                   kill the latched op
//   iw_pc/ow_pc                program counter
//   iw_instr/ow_instr          instruction word
//   iw_opc/ow_opc              opcode (ow_opc = NOP on bubbles)
//   iw_tgt_gp(_we)/ow_...      GP target and write enable
//   iw_tgt_sr(_we)/ow_...      SR target and write enable
//   iw_base, iw_offset         address operands
//   iw_result/ow_result        ALU result or store data
//   ow_mem_addr                latched effective address
//   ow_mem_mp                  latched port select (to stg_mo iw_mem_mp)
//   iw_mem_busy                per-bank busy
//   ow_stall                   hold stages 1-3
//   ow_mem_fault               one-cycle pulse after a timed-out op is dropped
//   ow_stall_cycles            (only with STG_MA_PERF_EN) saturating count
//                              of stalled cycles
// ---------------------------------------------------------------------------
module stg_ma
    import stg_ma_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic                   iw_clk,
    input  logic                   iw_rst,
    input  logic                   iw_flush,
    input  logic [SIZE_ADDR-1:0]   iw_pc,
    input  logic [SIZE_DATA-1:0]   iw_instr,
    input  logic [SIZE_OPC-1:0]    iw_opc,
    input  logic [SIZE_TGT_GP-1:0] iw_tgt_gp,
    input  logic                   iw_tgt_gp_we,
    input  logic [SIZE_TGT_SR-1:0] iw_tgt_sr,
    input  logic                   iw_tgt_sr_we,
    input  logic [SIZE_ADDR-1:0]   iw_base,
    input  logic [SIZE_ADDR-1:0]   iw_offset,
    input  logic [SIZE_DATA-1:0]   iw_result,
    input  logic [1:0]             iw_mem_busy,
    output logic [SIZE_ADDR-1:0]   ow_pc,
    output logic [SIZE_DATA-1:0]   ow_instr,
    output logic [SIZE_OPC-1:0]    ow_opc,
    output logic [SIZE_TGT_GP-1:0] ow_tgt_gp,
    output logic                   ow_tgt_gp_we,
    output logic [SIZE_TGT_SR-1:0] ow_tgt_sr,
    output logic                   ow_tgt_sr_we,
    output logic [SIZE_DATA-1:0]   ow_result,
    output logic [SIZE_ADDR-1:0]   ow_mem_addr,
    output logic                   ow_mem_mp,
    output logic                   ow_stall,
    output logic                   ow_mem_fault
`ifdef STG_MA_PERF_EN
    ,
    output logic [15:0]            ow_stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] WAIT_MAX_C = CNT_W'(WAIT_MAX);

    // ------------------------------------------------------------------
    // Address generation on the incoming bundle
    // ------------------------------------------------------------------
    logic [SIZE_ADDR-1:0] agu_ea;
    logic                 agu_mp;

    stg_ma_agu u_agu (
        .iw_base   (iw_base),
        .iw_offset (iw_offset),
        .ow_ea     (agu_ea),
        .ow_mp     (agu_mp)
    );

    ma_q_t q_in;

    assign q_in = '{
        pc:        iw_pc,
        instr:     iw_instr,
        opc:       iw_opc,
        tgt_gp:    iw_tgt_gp,
        tgt_gp_we: iw_tgt_gp_we,
        tgt_sr:    iw_tgt_sr,
        tgt_sr_we: iw_tgt_sr_we,
        result:    iw_result,
        ea:        agu_ea,
        mp:        agu_mp
    };

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ma_q_t             q_reg,     q_next;
    ma_state_e         state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg,   cnt_next;
    logic              fault_reg, fault_next;

    logic q_is_mem;
    logic sel_busy;
    logic stall;
    logic drop;
    logic bubble;

    assign q_is_mem = is_mem_opc(q_reg.opc);
    // Only the bank this op addresses matters; the other bank's busy is ignored.
    assign sel_busy = iw_mem_busy[q_reg.mp];

    // cnt counts cycles already spent stalled, so cnt < WAIT_MAX gives
    // exactly WAIT_MAX stall cycles before the drop cycle.
    assign stall  = q_is_mem && sel_busy && (cnt_reg < WAIT_MAX_C) && !iw_flush;
    assign drop   = q_is_mem && sel_busy && (state_reg == ST_WAIT) &&
                    (cnt_reg == WAIT_MAX_C);
    assign bubble = stall || drop || iw_flush;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        q_next     = q_reg;
        state_next = state_reg;
        cnt_next   = cnt_reg;
        fault_next = 1'b0;

        if (iw_flush) begin
            // Flush beats stall and drop; the killed op raises no fault.
            q_next     = '0;
            cnt_next   = '0;
            state_next = ST_RUN;
        end else if (stall) begin
            state_next = ST_WAIT;
            case (state_reg)
                ST_RUN:  cnt_next = CNT_W'(1);
                default: cnt_next = cnt_reg + 1'b1;
            endcase
        end else begin
            // Normal advance, busy clearing, or timeout drop: all take the
            // upstream op. Only the drop flags a fault for the next cycle.
            q_next     = q_in;
            cnt_next   = '0;
            state_next = ST_RUN;
            fault_next = drop;
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            q_reg     <= '0;
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
            fault_reg <= 1'b0;
        end else begin
            q_reg     <= q_next;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            fault_reg <= fault_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: bubbles clear opcode and write enables, payload stays
    // ------------------------------------------------------------------
    assign ow_pc        = q_reg.pc;
    assign ow_instr     = q_reg.instr;
    assign ow_opc       = bubble ? OPC_NOP : q_reg.opc;
    assign ow_tgt_gp    = q_reg.tgt_gp;
    assign ow_tgt_gp_we = bubble ? 1'b0 : q_reg.tgt_gp_we;
    assign ow_tgt_sr    = q_reg.tgt_sr;
    assign ow_tgt_sr_we = bubble ? 1'b0 : q_reg.tgt_sr_we;
    assign ow_result    = q_reg.result;
    assign ow_mem_addr  = q_reg.ea;
    assign ow_mem_mp    = q_reg.mp;
    assign ow_stall     = stall;
    assign ow_mem_fault = fault_reg;

`ifdef STG_MA_PERF_EN
    // ------------------------------------------------------------------
    // Stall-cycle counter: saturates at all-ones. Once saturated, a flush
    // no longer clears it, so the saturated reading survives until reset.
    // ------------------------------------------------------------------
    logic [15:0] stall_cycles_reg;

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            stall_cycles_reg <= '0;
        end else if (iw_flush) begin
            if (stall_cycles_reg != 16'hFFFF) begin
                stall_cycles_reg <= '0;
            end
        end else if (stall && (stall_cycles_reg != 16'hFFFF)) begin
            stall_cycles_reg <= stall_cycles_reg + 16'd1;
        end
    end

    assign ow_stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_stg_ma.sv
// ---------------------------------------------------------------------------
// tb_stg_ma -- directed self-checking bench for stg_ma.
//
// Each cycle the bench drives one upstream bundle plus busy/flush, pushes
// the output vector it expects for that cycle onto a scoreboard queue, then
// pops and compares it against the DUT outputs half a clock away from the
// active edge.
// ---------------------------------------------------------------------------
module tb_stg_ma;
    import stg_ma_pkg::*;

    logic                   iw_clk = 1'b0;
    logic                   iw_rst;
    logic                   iw_flush;
    logic [SIZE_ADDR-1:0]   iw_pc;
    logic [SIZE_DATA-1:0]   iw_instr;
    logic [SIZE_OPC-1:0]    iw_opc;
    logic [SIZE_TGT_GP-1:0] iw_tgt_gp;
    logic                   iw_tgt_gp_we;
    logic [SIZE_TGT_SR-1:0] iw_tgt_sr;
    logic                   iw_tgt_sr_we;
    logic [SIZE_ADDR-1:0]   iw_base;
    logic [SIZE_ADDR-1:0]   iw_offset;
    logic [SIZE_DATA-1:0]   iw_result;
    logic [1:0]             iw_mem_busy;
    logic [SIZE_ADDR-1:0]   ow_pc;
    logic [SIZE_DATA-1:0]   ow_instr;
    logic [SIZE_OPC-1:0]    ow_opc;
    logic [SIZE_TGT_GP-1:0] ow_tgt_gp;
    logic                   ow_tgt_gp_we;
    logic [SIZE_TGT_SR-1:0] ow_tgt_sr;
    logic                   ow_tgt_sr_we;
    logic [SIZE_DATA-1:0]   ow_result;
    logic [SIZE_ADDR-1:0]   ow_mem_addr;
    logic                   ow_mem_mp;
    logic                   ow_stall;
    logic                   ow_mem_fault;
`ifdef STG_MA_PERF_EN
    logic [15:0]            ow_stall_cycles;
`endif

    always #5 iw_clk = ~iw_clk;

    stg_ma #(.WAIT_MAX(15), .CNT_W(4)) dut (
        .iw_clk       (iw_clk),
        .iw_rst       (iw_rst),
        .iw_flush     (iw_flush),
        .iw_pc        (iw_pc),
        .iw_instr     (iw_instr),
        .iw_opc       (iw_opc),
        .iw_tgt_gp    (iw_tgt_gp),
        .iw_tgt_gp_we (iw_tgt_gp_we),
        .iw_tgt_sr    (iw_tgt_sr),
        .iw_tgt_sr_we (iw_tgt_sr_we),
        .iw_base      (iw_base),
        .iw_offset    (iw_offset),
        .iw_result    (iw_result),
        .iw_mem_busy  (iw_mem_busy),
        .ow_pc        (ow_pc),
        .ow_instr     (ow_instr),
        .ow_opc       (ow_opc),
        .ow_tgt_gp    (ow_tgt_gp),
        .ow_tgt_gp_we (ow_tgt_gp_we),
        .ow_tgt_sr    (ow_tgt_sr),
        .ow_tgt_sr_we (ow_tgt_sr_we),
        .ow_result    (ow_result),
        .ow_mem_addr  (ow_mem_addr),
        .ow_mem_mp    (ow_mem_mp),
        .ow_stall     (ow_stall),
        .ow_mem_fault (ow_mem_fault)
`ifdef STG_MA_PERF_EN
        ,
        .ow_stall_cycles (ow_stall_cycles)
`endif
    );

    typedef struct packed {
        logic [SIZE_ADDR-1:0]   pc;
        logic [SIZE_DATA-1:0]   instr;
        logic [SIZE_OPC-1:0]    opc;
        logic [SIZE_TGT_GP-1:0] gp;
        logic                   gp_we;
        logic [SIZE_TGT_SR-1:0] sr;
        logic                   sr_we;
        logic [SIZE_DATA-1:0]   result;
        logic [SIZE_ADDR-1:0]   base;
        logic [SIZE_ADDR-1:0]   offset;
    } op_t;

    typedef struct packed {
        logic [SIZE_ADDR-1:0]   pc;
        logic [SIZE_DATA-1:0]   instr;
        logic [SIZE_OPC-1:0]    opc;
        logic [SIZE_TGT_GP-1:0] gp;
        logic                   gp_we;
        logic [SIZE_TGT_SR-1:0] sr;
        logic                   sr_we;
        logic [SIZE_DATA-1:0]   result;
        logic [SIZE_ADDR-1:0]   addr;
        logic                   mp;
        logic                   stall;
        logic                   fault;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_stall_cycles = 0;
    exp_t zero_exp = '0;

    // Op presented unmasked; ea is supplied as a hand-computed constant.
    function automatic exp_t pres(input op_t o, input logic [SIZE_ADDR-1:0] ea,
                                  input logic fault);
        exp_t e;
        e.pc     = o.pc;
        e.instr  = o.instr;
        e.opc    = o.opc;
        e.gp     = o.gp;
        e.gp_we  = o.gp_we;
        e.sr     = o.sr;
        e.sr_we  = o.sr_we;
        e.result = o.result;
        e.addr   = ea;
        e.mp     = ea[SIZE_ADDR-1];
        e.stall  = 1'b0;
        e.fault  = fault;
        return e;
    endfunction

    // Same op as a bubble: opcode NOP, write enables off, payload kept.
    function automatic exp_t bub(input exp_t e_in, input logic stall);
        exp_t e;
        e       = e_in;
        e.opc   = OPC_NOP;
        e.gp_we = 1'b0;
        e.sr_we = 1'b0;
        e.stall = stall;
        return e;
    endfunction

    task automatic drive(input op_t o, input logic [1:0] busy, input logic flush);
        iw_pc        = o.pc;
        iw_instr     = o.instr;
        iw_opc       = o.opc;
        iw_tgt_gp    = o.gp;
        iw_tgt_gp_we = o.gp_we;
        iw_tgt_sr    = o.sr;
        iw_tgt_sr_we = o.sr_we;
        iw_result    = o.result;
        iw_base      = o.base;
        iw_offset    = o.offset;
        iw_mem_busy  = busy;
        iw_flush     = flush;
    endtask

    task automatic check(input string tag);
        exp_t want;
        exp_t got;
        want = sb.pop_front();
        got  = {ow_pc, ow_instr, ow_opc, ow_tgt_gp, ow_tgt_gp_we, ow_tgt_sr,
                ow_tgt_sr_we, ow_result, ow_mem_addr, ow_mem_mp, ow_stall,
                ow_mem_fault};
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
`ifdef STG_MA_PERF_EN
        n_cmp++;
        assert (ow_stall_cycles === 16'(exp_stall_cycles)) else begin
            n_bad++;
            $error("FAIL %s_perf: observed %0d expected %0d", tag,
                   ow_stall_cycles, exp_stall_cycles);
        end
`endif
    endtask

    // One clock cycle: drive, queue the expectation, sample at negedge+1.
    task automatic cyc(input op_t o, input logic [1:0] busy, input logic flush,
                       input exp_t e, input string tag);
        @(negedge iw_clk);
        drive(o, busy, flush);
        sb.push_back(e);
        #1;
        check(tag);
        if (flush) exp_stall_cycles = 0;
        else if (e.stall) exp_stall_cycles++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t nop0, ld1, st2, alu3, ld4, ld5, st6, alu7;
        nop0 = '0;
        ld1  = '{pc:16'h0100, instr:32'h0000_00A1, opc:OPC_RU_LDu,  gp:4'd3, gp_we:1'b1,
                 sr:2'd0, sr_we:1'b0, result:32'h1111_1111, base:16'h0010, offset:16'h0004};
        st2  = '{pc:16'h0200, instr:32'h0000_00B2, opc:OPC_RU_STu,  gp:4'd1, gp_we:1'b1,
                 sr:2'd1, sr_we:1'b1, result:32'hCAFE_0002, base:16'h8000, offset:16'h0123};
        alu3 = '{pc:16'h0300, instr:32'h0000_00C3, opc:OPC_RU_ADD,  gp:4'd5, gp_we:1'b1,
                 sr:2'd2, sr_we:1'b0, result:32'hDEAD_BEEF, base:16'hFFFF, offset:16'h0002};
        ld4  = '{pc:16'h0400, instr:32'h0000_00D4, opc:OPC_RU_LDu,  gp:4'd7, gp_we:1'b1,
                 sr:2'd0, sr_we:1'b0, result:32'h0000_0044, base:16'h1000, offset:16'h0200};
        ld5  = '{pc:16'h0500, instr:32'h0000_00E5, opc:OPC_IU_STiu, gp:4'd0, gp_we:1'b0,
                 sr:2'd0, sr_we:1'b0, result:32'h0000_0055, base:16'h0100, offset:16'h0010};
        st6  = '{pc:16'h0600, instr:32'h0000_00F6, opc:OPC_IS_STis, gp:4'd2, gp_we:1'b1,
                 sr:2'd3, sr_we:1'b1, result:32'h6666_6666, base:16'h4000, offset:16'h4000};
        alu7 = '{pc:16'h0700, instr:32'h0000_0017, opc:OPC_RU_ADD,  gp:4'd9, gp_we:1'b1,
                 sr:2'd1, sr_we:1'b1, result:32'h7777_7777, base:16'h0003, offset:16'h0004};

        // Reset state
        iw_rst = 1'b1;
        drive(nop0, 2'b11, 1'b0);
        repeat (2) @(negedge iw_clk);
        #1;
        sb.push_back(zero_exp);
        check("reset");
        @(negedge iw_clk);
        iw_rst = 1'b0;

        // Test 1: LDu, 1-cycle latency, ea = 0x014
        cyc(ld1,  2'b00, 1'b0, zero_exp,                         "t1_idle");
        cyc(nop0, 2'b00, 1'b0, pres(ld1, 16'h0014, 1'b0),        "t1_ldu");

        // Test 2: STu to bank 1, bank 1 busy 3 cycles, then presented once
        cyc(st2,  2'b00, 1'b0, zero_exp,                         "t2_nop_out");
        for (int i = 0; i < 3; i++)
            cyc(alu3, 2'b10, 1'b0, bub(pres(st2, 16'h8123, 1'b0), 1'b1), "t2_stall");
        cyc(alu3, 2'b01, 1'b0, pres(st2, 16'h8123, 1'b0),        "t2_present");

        // Test 5: non-memory op ignores busy, ea wraps to 0x0001
        cyc(ld4,  2'b11, 1'b0, pres(alu3, 16'h0001, 1'b0),       "t5_nonmem_wrap");

        // Test 3: bank 0 busy forever -> 15 stalls, drop, fault pulse
        for (int i = 0; i < 15; i++)
            cyc(ld5, 2'b01, 1'b0, bub(pres(ld4, 16'h1200, 1'b0), 1'b1), "t3_stall");
        cyc(ld5,  2'b01, 1'b0, bub(pres(ld4, 16'h1200, 1'b0), 1'b0), "t3_drop");
        cyc(nop0, 2'b00, 1'b0, pres(ld5, 16'h0110, 1'b1),        "t3_fault_next");
        cyc(st6,  2'b00, 1'b0, zero_exp,                         "t3_fault_clear");

        // Test 4: flush on second WAIT cycle
        cyc(alu7, 2'b10, 1'b0, bub(pres(st6, 16'h8000, 1'b0), 1'b1), "t4_wait1");
        cyc(alu7, 2'b10, 1'b1, bub(pres(st6, 16'h8000, 1'b0), 1'b0), "t4_flush");
        cyc(alu7, 2'b10, 1'b0, zero_exp,                         "t4_q_zero");
        cyc(nop0, 2'b00, 1'b0, pres(alu7, 16'h0007, 1'b0),       "t4_no_fault");

        // Test 6: asynchronous reset in the middle of WAIT
        cyc(ld1,  2'b00, 1'b0, zero_exp,                         "t6_latch");
        cyc(nop0, 2'b01, 1'b0, bub(pres(ld1, 16'h0014, 1'b0), 1'b1), "t6_wait1");
        cyc(nop0, 2'b01, 1'b0, bub(pres(ld1, 16'h0014, 1'b0), 1'b1), "t6_wait2");
        #2;
        iw_rst = 1'b1;
        #1;
        exp_stall_cycles = 0;
        sb.push_back(zero_exp);
        check("t6_rst_async");
        @(negedge iw_clk);
        iw_rst = 1'b0;
        cyc(nop0, 2'b11, 1'b0, zero_exp,                         "t6_after_rst");
        cyc(ld1,  2'b01, 1'b0, zero_exp,                         "t6_relatch");
        cyc(nop0, 2'b01, 1'b0, bub(pres(ld1, 16'h0014, 1'b0), 1'b1), "t6_stall");
        cyc(nop0, 2'b00, 1'b0, pres(ld1, 16'h0014, 1'b0),        "t6_present");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stg_ma.md
Name: stg_ma

Overview:
- Stage 4, memory-address stage; feeds stg_mo (stage 5) directly.
- Computes the effective address ea = base + offset and selects the memory port.
- Latches the pipeline bundle and presents address, port select and payload to stage 5.
- Stalls upstream while the selected memory bank is busy, sending bubbles downstream so stage 5 never repeats a store.
- Bounded wait: the op is dropped and a fault is raised on timeout.

Parameters:
- WAIT_MAX, 15: maximum stalled cycles before the op is dropped; 1..(2^CNT_W)-1.
- CNT_W, 4: wait-counter width.

Ports:
- iw_clk  in  1  clock.
- iw_rst  in  1  reset, asynchronous, active-high.
- iw_flush  in  1  kill the latched op.
- iw_pc / ow_pc  in/out  SIZE_ADDR  program counter.
- iw_instr / ow_instr  in/out  SIZE_DATA  instruction word.
- iw_opc / ow_opc  in/out  SIZE_OPC  opcode.
- iw_tgt_gp, iw_tgt_gp_we / ow_tgt_gp, ow_tgt_gp_we  in/out  SIZE_TGT_GP, 1  GP target and write enable.
- iw_tgt_sr, iw_tgt_sr_we / ow_tgt_sr, ow_tgt_sr_we  in/out  SIZE_TGT_SR, 1  SR target and write enable.
- iw_base  in  SIZE_ADDR  address base operand.
- iw_offset  in  SIZE_ADDR  address offset operand.
- iw_result / ow_result  in/out  SIZE_DATA  ALU result or store data.
- ow_mem_addr  out  SIZE_ADDR  latched ea, shared by both banks.
- ow_mem_mp  out  1  port select, feeds stg_mo iw_mem_mp.
- iw_mem_busy  in  2  per-bank busy.
- ow_stall  out  1  hold stages 1-3.
- ow_mem_fault  out  1  one-cycle pulse: op dropped on timeout.

Behaviour:
- Memory ops are OPC_RU_LDu, OPC_RU_STu, OPC_IU_STiu and OPC_IS_STis. All other opcodes pass through with no stall.
- ea = iw_base + iw_offset, modulo 2^SIZE_ADDR; carry discarded. mp = ea[HBIT_ADDR].
- Latch set Q holds pc, instr, opc, tgt_gp/we, tgt_sr/we, result, ea and mp. Outputs are driven from Q.
- Latency: 1 cycle input-to-output when not stalled.
- Reset: all Q fields 0, state RUN, cnt 0, ow_mem_fault 0. Hence every output resets to 0, including ow_stall. Reset mid-WAIT aborts the op; no fault is raised.
- stall (combinational) = q_is_mem && iw_mem_busy[q_mp] && (cnt < WAIT_MAX) && !iw_flush. ow_stall = stall.
- Bubble output: while stall, drop or iw_flush, ow_opc = 0 (NOP encoding) and ow_tgt_gp_we = ow_tgt_sr_we = 0. Other outputs keep Q values.
- drop (combinational) = q_is_mem && iw_mem_busy[q_mp] && cnt == WAIT_MAX.
- FSM RUN:
  - Not stall: Q <= inputs, cnt stays 0.
  - Stall: Q held, cnt <= 1, go to WAIT.
- FSM WAIT:
  - Stall: Q held, cnt <= cnt+1.
  - Busy clears: Q is presented unmasked for exactly that cycle; Q <= inputs, cnt <= 0, go to RUN.
  - Drop: outputs bubbled; Q <= inputs, cnt <= 0, ow_mem_fault <= 1 for the next cycle, go to RUN.
- Resulting timing with busy held: exactly WAIT_MAX stalled cycles, then 1 drop cycle.
- iw_flush, any state: outputs bubbled that cycle; Q <= all-zero, cnt <= 0, go to RUN. Flush takes priority over stall and drop; no fault is raised.
- Busy on the non-selected bank is ignored.
- Back-to-back memory ops are allowed; each op is evaluated independently.

Optional Feature:
- Macro STG_MA_PERF_EN.
- Defined:
  - Adds output ow_stall_cycles, 16 bits: saturating count of cycles with ow_stall=1.
  - Reset to 0; cleared by iw_flush only if it is not already saturated at 0xFFFF.
- Undefined: port absent; no counter logic.

Decomposition:
- Opcode and size constants come from the existing opcodes and sizes headers.
- Add to the shared package: OPC_NOP = 0 and an is_mem_opc function covering the four memory opcodes. stg_mo can reuse both.
- One natural sub-module: stg_ma_agu, combinational ea/mp generation (adder plus bank-select bit).
- The FSM and latches stay in stg_ma.

Test Plan:
1. LDu, base 0x010, offset 0x004, busy=00 -> next cycle ow_opc=LDu, ow_mem_addr=0x014, ow_mem_mp=0, ow_stall=0.
2. STu with ea top bit set, busy[1]=1 for 3 cycles -> ow_stall=1 for 3 cycles with ow_opc=0; then STu presented once with ow_mem_mp=1 and ow_pc unchanged.
3. Busy[0] held forever on LDu, WAIT_MAX=15 -> 15 stall cycles, 1 drop cycle, ow_mem_fault=1 for one cycle; next upstream op latched.
4. iw_flush on the 2nd WAIT cycle -> bubble that cycle, then Q=0, ow_stall=0, no fault.
5. Non-memory opcode with busy=11 -> no stall, passes with 1-cycle latency; ea wrap with base=all-ones, offset=2 -> ow_mem_addr=1.
6. iw_rst asserted mid-WAIT -> all outputs 0 immediately, state RUN, cnt 0; with STG_MA_PERF_EN, ow_stall_cycles=0.
